// File: rtl/trace_monitor.sv
// trace_monitor: captures architectural register writes from writeback into a
// first-word-fall-through trace FIFO and counts cycles, captured writes and
// dropped writes. A run ends on HALT_ZEROS consecutive all-zero decode
// instructions or on the MAX_CYCLES budget. The FIFO then drains and the halt
// cause is reported.
// Optional feature: define TRACE_MONITOR_PC_EN to store pc_i in each entry and
// present the head PC on trc_pc_o.
module trace_monitor #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned HALT_ZEROS = 1,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     wb_we_i,
    input  logic [REG_ADDR_W-1:0]    wb_rd_i,
    input  logic [XLEN-1:0]          wb_data_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [31:0]              instr_i,
    output logic                     trc_valid_o,
    input  logic                     trc_ready_i,
    output logic [CNT_W-1:0]         trc_cycle_o,
    output logic [REG_ADDR_W-1:0]    trc_rd_o,
    output logic [XLEN-1:0]          trc_data_o,
    output logic                     halted_o,
    output logic                     done_o,
    output logic [1:0]               halt_cause_o,
    output logic [CNT_W-1:0]         cycle_cnt_o,
    output logic [CNT_W-1:0]         wr_cnt_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic                     overflow_o,
`ifdef TRACE_MONITOR_PC_EN
    output logic [XLEN-1:0]          trc_pc_o,
`endif
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned ZW = $clog2(HALT_ZEROS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] CAUSE_ZERO = 2'b01;
    localparam logic [1:0] CAUSE_TMO  = 2'b10;

    localparam logic [CNT_W-1:0] TMO_AT = CNT_W'(MAX_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cycle_q, cycle_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]      drop_q, drop_d;
    logic                  ovf_q, ovf_d;
    logic [1:0]            cause_q, cause_d;
    logic [ZW-1:0]         zcnt_q, zcnt_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         count_q, count_d;

    logic [CNT_W-1:0]      mem_cycle_q [DEPTH];
    logic [REG_ADDR_W-1:0] mem_rd_q    [DEPTH];
    logic [XLEN-1:0]       mem_data_q  [DEPTH];
`ifdef TRACE_MONITOR_PC_EN
    logic [XLEN-1:0]       mem_pc_q    [DEPTH];
`endif

    logic                  full, pop, push_req, push_ok, drop;
    logic [ZW-1:0]         zsum;
    logic                  halt_zero, timeout;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Next-state: FIFO handshake, run FSM, halt detection and counters
    always_comb begin
        full      = (count_q == LW'(DEPTH));
        pop       = (count_q != '0) && trc_ready_i;
        push_req  = (state_q == S_RUN) && wb_we_i && (wb_rd_i != '0);
        push_ok   = push_req && (!full || pop);
        drop      = push_req && full && !pop;
        zsum      = zcnt_q + ZW'(1);
        halt_zero = (instr_i == '0) && (zsum == ZW'(HALT_ZEROS));
        timeout   = (MAX_CYCLES != 0) && (cycle_q == TMO_AT);

        state_d  = state_q;
        cycle_d  = cycle_q;
        wr_cnt_d = wr_cnt_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        cause_d  = cause_q;
        zcnt_d   = zcnt_q;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + LW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - LW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                cycle_d = sat_inc(cycle_q);
                if (push_ok) wr_cnt_d = sat_inc(wr_cnt_q);
                if (drop) begin
                    drop_d = sat_inc(drop_q);
                    ovf_d  = 1'b1;
                end
                zcnt_d = (instr_i == '0) ? zsum : '0;
                if (halt_zero) begin
                    cause_d = CAUSE_ZERO;
                    state_d = S_DRAIN;
                end else if (timeout) begin
                    cause_d = CAUSE_TMO;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (count_q == '0) state_d = S_DONE;
            end
            default: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    cycle_d  = '0;
                    wr_cnt_d = '0;
                    drop_d   = '0;
                    ovf_d    = 1'b0;
                    cause_d  = 2'b00;
                    zcnt_d   = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end
            end
        endcase
    end

    // Control and counter registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cycle_q  <= '0;
            wr_cnt_q <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            cause_q  <= 2'b00;
            zcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            wr_cnt_q <= wr_cnt_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            cause_q  <= cause_d;
            zcnt_q   <= zcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Trace storage; contents are only observable through the valid-gated head
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_cycle_q[wr_ptr_q] <= cycle_q;
            mem_rd_q[wr_ptr_q]    <= wb_rd_i;
            mem_data_q[wr_ptr_q]  <= wb_data_i;
`ifdef TRACE_MONITOR_PC_EN
            mem_pc_q[wr_ptr_q]    <= pc_i;
`endif
        end
    end

`ifndef TRACE_MONITOR_PC_EN
    logic unused_pc;
    assign unused_pc = ^pc_i;
`endif

    // Fall-through head presentation, forced to zero while empty
    always_comb begin
        trc_valid_o = (count_q != '0);
        trc_cycle_o = '0;
        trc_rd_o    = '0;
        trc_data_o  = '0;
`ifdef TRACE_MONITOR_PC_EN
        trc_pc_o    = '0;
`endif
        if (trc_valid_o) begin
            trc_cycle_o = mem_cycle_q[rd_ptr_q];
            trc_rd_o    = mem_rd_q[rd_ptr_q];
            trc_data_o  = mem_data_q[rd_ptr_q];
`ifdef TRACE_MONITOR_PC_EN
            trc_pc_o    = mem_pc_q[rd_ptr_q];
`endif
        end
    end

    assign halted_o     = (state_q == S_DRAIN) || (state_q == S_DONE);
    assign done_o       = (state_q == S_DONE);
    assign halt_cause_o = cause_q;
    assign cycle_cnt_o  = cycle_q;
    assign wr_cnt_o     = wr_cnt_q;
    assign drop_cnt_o   = drop_q;
    assign overflow_o   = ovf_q;
    assign level_o      = count_q;

endmodule

// File: tb/tb_trace_monitor.sv
// Testbench for trace_monitor: directed scenarios followed by random runs,
// compared against a transaction-level reference model and an entry scoreboard.
module tb_trace_monitor;
    localparam int XLEN  = 32;
    localparam int RAW   = 5;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;
    localparam int HZ    = 2;
    localparam int MAXC  = 10;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NZ = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_i, start_i, wb_we_i, trc_ready_i;
    logic [RAW-1:0]  wb_rd_i;
    logic [XLEN-1:0] wb_data_i, pc_i;
    logic [31:0]     instr_i;
    logic            trc_valid_o, halted_o, done_o, overflow_o;
    logic [CNT_W-1:0] trc_cycle_o, cycle_cnt_o, wr_cnt_o, drop_cnt_o;
    logic [RAW-1:0]  trc_rd_o;
    logic [XLEN-1:0] trc_data_o;
    logic [1:0]      halt_cause_o;
    logic [LW-1:0]   level_o;
`ifdef TRACE_MONITOR_PC_EN
    logic [XLEN-1:0] trc_pc_o;
`endif

    always #5 clk = ~clk;

    trace_monitor #(
        .XLEN(XLEN), .REG_ADDR_W(RAW), .DEPTH(DEPTH), .CNT_W(CNT_W),
        .HALT_ZEROS(HZ), .MAX_CYCLES(MAXC)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .pc_i(pc_i), .instr_i(instr_i),
        .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i),
        .trc_cycle_o(trc_cycle_o), .trc_rd_o(trc_rd_o), .trc_data_o(trc_data_o),
        .halted_o(halted_o), .done_o(done_o), .halt_cause_o(halt_cause_o),
        .cycle_cnt_o(cycle_cnt_o), .wr_cnt_o(wr_cnt_o), .drop_cnt_o(drop_cnt_o),
        .overflow_o(overflow_o),
`ifdef TRACE_MONITOR_PC_EN
        .trc_pc_o(trc_pc_o),
`endif
        .level_o(level_o)
    );

    typedef struct {
        longint cyc;
        int     rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } entry_t;

    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mode_t;

    entry_t sb[$];
    int checks = 0;
    int errors = 0;

    mode_t  mode   = M_IDLE;
    longint m_cyc  = 0;
    longint m_wr   = 0;
    longint m_drop = 0;
    int     m_level = 0;
    int     m_zeros = 0;
    int     m_cause = 0;
    bit     m_ovf   = 1'b0;
    localparam longint SATV = (64'd1 << CNT_W) - 1;

    function automatic longint sat(input longint v);
        return (v < SATV) ? v + 1 : v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per rising edge using the inputs held for it
    task automatic model_step();
        bit pop, push;
        entry_t e;
        if (rst_i) begin
            mode = M_IDLE; m_cyc = 0; m_wr = 0; m_drop = 0; m_level = 0;
            m_zeros = 0; m_cause = 0; m_ovf = 1'b0;
            sb.delete();
            return;
        end
        pop  = (m_level > 0) && trc_ready_i;
        push = 1'b0;
        case (mode)
            M_IDLE: if (start_i) mode = M_RUN;
            M_RUN: begin
                if (wb_we_i && wb_rd_i != 0) begin
                    if (m_level < DEPTH || pop) begin
                        push = 1'b1;
                        e.cyc = m_cyc; e.rd = int'(wb_rd_i); e.data = wb_data_i; e.pc = pc_i;
                        sb.push_back(e);
                        m_wr = sat(m_wr);
                    end else begin
                        m_drop = sat(m_drop);
                        m_ovf  = 1'b1;
                    end
                end
                m_zeros = (instr_i == 0) ? m_zeros + 1 : 0;
                if (m_zeros >= HZ) begin
                    m_cause = 1; mode = M_DRAIN;
                end else if (MAXC != 0 && m_cyc == MAXC - 1) begin
                    m_cause = 2; mode = M_DRAIN;
                end
                m_cyc = sat(m_cyc);
            end
            M_DRAIN: if (m_level == 0) mode = M_DONE;
            M_DONE: if (start_i) begin
                mode = M_RUN; m_cyc = 0; m_wr = 0; m_drop = 0;
                m_zeros = 0; m_cause = 0; m_ovf = 1'b0;
            end
            default: ;
        endcase
        m_level = m_level + int'(push) - int'(pop);
    endtask

    // Monitor: status against the model, head entries against the scoreboard
    always @(negedge clk) begin
        entry_t e;
        chk("valid", trc_valid_o, m_level != 0);
        chk("level", level_o, m_level);
        chk("halted", halted_o, (mode == M_DRAIN) || (mode == M_DONE));
        chk("done", done_o, mode == M_DONE);
        chk("cause", halt_cause_o, m_cause);
        chk("cycle_cnt", cycle_cnt_o, m_cyc);
        chk("wr_cnt", wr_cnt_o, m_wr);
        chk("drop_cnt", drop_cnt_o, m_drop);
        chk("overflow", overflow_o, m_ovf);
        if (!trc_valid_o) begin
            chk("empty_cycle", trc_cycle_o, 0);
            chk("empty_rd", trc_rd_o, 0);
            chk("empty_data", trc_data_o, 0);
`ifdef TRACE_MONITOR_PC_EN
            chk("empty_pc", trc_pc_o, 0);
`endif
        end else if (trc_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_entry", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("head_cycle", trc_cycle_o, e.cyc);
                chk("head_rd", trc_rd_o, e.rd);
                chk("head_data", trc_data_o, e.data);
`ifdef TRACE_MONITOR_PC_EN
                chk("head_pc", trc_pc_o, e.pc);
`endif
            end
        end
    end

    task automatic drive(input bit rst, input bit st, input bit we, input int rd,
                         input logic [XLEN-1:0] d, input logic [XLEN-1:0] pc,
                         input logic [31:0] ins, input bit rdy);
        rst_i = rst; start_i = st; wb_we_i = we; wb_rd_i = RAW'(rd);
        wb_data_i = d; pc_i = pc; instr_i = ins; trc_ready_i = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n, input logic [31:0] ins, input bit rdy);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, '0, '0, ins, rdy);
    endtask

    initial begin
        // Reset
        drive(1, 0, 0, 0, '0, '0, NZ, 0);
        drive(1, 0, 0, 0, '0, '0, NZ, 0);
        // Basic capture: x5=7 at RUN cycle 0, x6=-3 at cycle 2
        drive(0, 1, 0, 0, '0, '0, NZ, 1);
        drive(0, 0, 1, 5, 32'd7, 32'h10000, NZ, 1);
        drive(0, 0, 0, 0, '0, '0, NZ, 1);
        drive(0, 0, 1, 6, 32'hFFFF_FFFD, 32'h10004, NZ, 1);
        idle(2, 32'd0, 1);
        idle(4, NZ, 1);
        // Restart from DONE; x0 write ignored; zero-instruction halt
        drive(0, 1, 0, 0, '0, '0, NZ, 1);
        drive(0, 0, 0, 0, '0, '0, NZ, 1);
        drive(0, 0, 1, 0, 32'd9, 32'h20000, NZ, 1);
        idle(2, NZ, 1);
        idle(2, 32'd0, 1);
        idle(4, NZ, 1);
        // Overflow with ready low, start_i in RUN ignored, push+pop while full
        drive(0, 1, 0, 0, '0, '0, NZ, 0);
        for (int i = 0; i < 6; i++)
            drive(0, i == 2, 1, i + 1, 32'(100 + i), 32'(32'h300 + 4 * i), NZ, 0);
        drive(0, 0, 1, 9, 32'hABCD, 32'h10004, NZ, 1);
        idle(10, NZ, 1);
        // Timeout with writes every cycle
        drive(0, 1, 0, 0, '0, '0, NZ, 1);
        for (int i = 0; i < 12; i++)
            drive(0, 0, 1, 1 + (i % 31), $urandom, $urandom, NZ, 1);
        idle(6, NZ, 1);
        // Zero halt and timeout in the same cycle
        drive(0, 1, 0, 0, '0, '0, NZ, 1);
        idle(MAXC - HZ, NZ, 1);
        idle(HZ, 32'd0, 1);
        idle(4, NZ, 1);
        // Reset mid-run with three entries queued
        drive(0, 1, 0, 0, '0, '0, NZ, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 10 + i, 32'(i), '0, NZ, 0);
        drive(1, 0, 0, 0, '0, '0, NZ, 0);
        idle(2, NZ, 1);
        // Randomised runs
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            ins = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | 32'd1);
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
                  $urandom, $urandom, ins, $urandom_range(0, 3) != 0);
        end
        idle(2, NZ, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
